// File: rtl/bp_be_pkg.sv
// Backend shared types: processor config selector and the
// prefetch scheduler state encoding.
package bp_be_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg
  } bp_params_e;

  typedef enum logic [0:0] {
    e_idle,
    e_issue
  } bp_be_pf_sched_state_e;

  function automatic int vaddr_width_f(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 39;
      default:          return 39;
    endcase
  endfunction

  function automatic int dcache_block_width_f(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 512;
      default:          return 512;
    endcase
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small 1-read 1-write FIFO; ready_o is a pure function of the
// registered count, so a same-cycle pop never frees a slot early.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);
  localparam logic [ptr_w_lp-1:0] last_lp = ptr_w_lp'(els_p - 1);
  localparam logic [cnt_w_lp-1:0] full_lp = cnt_w_lp'(els_p);

  logic [width_p-1:0]  r_mem [els_p];
  logic [ptr_w_lp-1:0] r_rptr;
  logic [ptr_w_lp-1:0] r_wptr;
  logic [cnt_w_lp-1:0] r_cnt;

  logic w_enq;
  logic w_deq;

  assign ready_o = (r_cnt != full_lp);
  assign v_o     = (r_cnt != '0);
  assign data_o  = r_mem[r_rptr];
  assign w_enq   = v_i & ready_o;
  assign w_deq   = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_mem[r_wptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rptr <= '0;
      r_wptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_enq) begin
        r_wptr <= (r_wptr == last_lp) ? '0 : r_wptr + 1'b1;
      end
      if (w_deq) begin
        r_rptr <= (r_rptr == last_lp) ? '0 : r_rptr + 1'b1;
      end
      r_cnt <= r_cnt + cnt_w_lp'(w_enq) - cnt_w_lp'(w_deq);
    end
  end

endmodule

// File: rtl/bp_be_prefetch_scheduler.sv
// Turns confirmed stride candidates into degree_p D$ prefetches,
// suppressing blocks issued recently via a small round-robin filter.
module bp_be_prefetch_scheduler
  import bp_be_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int stride_width_p = 8,
  parameter int fifo_els_p     = 4,
  parameter int degree_p       = 2,
  parameter int filter_els_p   = 4,
  localparam int vaddr_width_p = vaddr_width_f(bp_params_p),
  localparam int dcache_block_width_p = dcache_block_width_f(bp_params_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      flush_i,
  input  logic                      cand_v_i,
  input  logic                      cand_confirm_i,
  input  logic [vaddr_width_p-1:0]  cand_addr_i,
  input  logic [stride_width_p-1:0] cand_stride_i,
  output logic                      cand_ready_o,
  output logic                      pf_v_o,
  output logic [vaddr_width_p-1:0]  pf_addr_o,
  input  logic                      pf_yumi_i,
  output logic                      idle_o
);

  localparam int off_w_lp  = $clog2(dcache_block_width_p / 8);
  localparam int tag_w_lp  = vaddr_width_p - off_w_lp;
  localparam int rem_w_lp  = $clog2(degree_p + 1);
  localparam int rr_w_lp   = (filter_els_p > 1) ? $clog2(filter_els_p) : 1;
  localparam int entry_w_lp = vaddr_width_p + stride_width_p;
  localparam int ext_w_lp  = vaddr_width_p - stride_width_p;
  localparam logic [rr_w_lp-1:0]  rr_last_lp = rr_w_lp'(filter_els_p - 1);
  localparam logic [rem_w_lp-1:0] degree_lp  = rem_w_lp'(degree_p);
  localparam logic [rem_w_lp-1:0] one_lp     = rem_w_lp'(1);

  logic                      w_fifo_v;
  logic                      w_fifo_ready;
  logic                      w_fifo_yumi;
  logic                      w_fifo_reset;
  logic                      w_enq_v;
  logic [entry_w_lp-1:0]     w_fifo_data;
  logic [vaddr_width_p-1:0]  w_head_addr;
  logic [stride_width_p-1:0] w_head_stride;
  logic [vaddr_width_p-1:0]  w_head_sext;
  logic [vaddr_width_p-1:0]  w_stride_sext;
  logic [tag_w_lp-1:0]       w_cur_tag;
  logic                      w_hit;
  logic                      w_issue;
  logic                      w_step;
  logic                      w_consume;

  bp_be_pf_sched_state_e     r_state;
  logic [vaddr_width_p-1:0]  r_cur;
  logic [stride_width_p-1:0] r_stride;
  logic [rem_w_lp-1:0]       r_rem;
  logic [filter_els_p-1:0]   r_filt_v;
  logic [tag_w_lp-1:0]       r_filt_tag [filter_els_p];
  logic [rr_w_lp-1:0]        r_rr;

  // Flush drops queued candidates through the FIFO's own reset.
  assign w_fifo_reset = reset_i | flush_i;
  assign w_enq_v = cand_v_i & cand_confirm_i
                 & (|cand_stride_i) & ~flush_i;
  assign w_fifo_yumi = (r_state == e_idle) & w_fifo_v & ~flush_i;

  bsg_fifo_1r1w_small #(
    .width_p (entry_w_lp),
    .els_p   (fifo_els_p)
  ) cand_fifo (
    .clk_i   (clk_i),
    .reset_i (w_fifo_reset),
    .v_i     (w_enq_v),
    .data_i  ({cand_addr_i, cand_stride_i}),
    .ready_o (w_fifo_ready),
    .v_o     (w_fifo_v),
    .data_o  (w_fifo_data),
    .yumi_i  (w_fifo_yumi)
  );

  assign {w_head_addr, w_head_stride} = w_fifo_data;
  assign w_head_sext =
    {{ext_w_lp{w_head_stride[stride_width_p-1]}}, w_head_stride};
  assign w_stride_sext =
    {{ext_w_lp{r_stride[stride_width_p-1]}}, r_stride};

  assign w_cur_tag = r_cur[vaddr_width_p-1:off_w_lp];

  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < filter_els_p; i++) begin
      if (r_filt_v[i] && (r_filt_tag[i] == w_cur_tag)) begin
        w_hit = 1'b1;
      end
    end
  end

  assign w_issue   = (r_state == e_issue);
  assign w_step    = w_issue & (w_hit | pf_yumi_i);
  assign w_consume = pf_v_o & pf_yumi_i & ~flush_i;

  assign cand_ready_o = w_fifo_ready;
  assign pf_v_o       = w_issue & ~w_hit;
  assign pf_addr_o    = r_cur;
  assign idle_o       = (r_state == e_idle) & ~w_fifo_v;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state  <= e_idle;
      r_cur    <= '0;
      r_stride <= '0;
      r_rem    <= '0;
      r_filt_v <= '0;
      r_rr     <= '0;
      for (int i = 0; i < filter_els_p; i++) begin
        r_filt_tag[i] <= '0;
      end
    end else if (flush_i) begin
      r_state  <= e_idle;
      r_filt_v <= '0;
      r_rr     <= '0;
    end else begin
      unique case (r_state)
        e_idle: begin
          if (w_fifo_v) begin
            r_cur    <= w_head_addr + w_head_sext;
            r_stride <= w_head_stride;
            r_rem    <= degree_lp;
            r_state  <= e_issue;
          end
        end
        e_issue: begin
          if (w_step) begin
            r_cur <= r_cur + w_stride_sext;
            r_rem <= r_rem - 1'b1;
            if (r_rem == one_lp) begin
              r_state <= e_idle;
            end
          end
        end
        default: r_state <= e_idle;
      endcase
      if (w_consume) begin
        r_filt_v[r_rr]   <= 1'b1;
        r_filt_tag[r_rr] <= w_cur_tag;
        r_rr <= (r_rr == rr_last_lp) ? '0 : r_rr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bp_be_prefetch_scheduler.sv
// Scoreboard bench for the stride prefetch scheduler.
// Expected addresses come from a reference filter model.
module tb_bp_be_prefetch_scheduler;

  localparam int VA  = 39;
  localparam int OFF = 6;
  localparam int DEG = 2;
  localparam int FE  = 4;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          flush_i = 1'b0;
  logic          cand_v_i = 1'b0;
  logic          cand_confirm_i = 1'b0;
  logic [VA-1:0] cand_addr_i = '0;
  logic [7:0]    cand_stride_i = '0;
  logic          cand_ready_o;
  logic          pf_v_o;
  logic [VA-1:0] pf_addr_o;
  logic          pf_yumi_i = 1'b0;
  logic          idle_o;

  logic [VA-1:0]     sb_q [$];
  logic [VA-1:0]     mon_exp;
  logic [VA-OFF-1:0] m_tag [FE];
  bit                m_v [FE];
  int                m_rr;
  int                n_chk = 0;
  int                n_fail = 0;

  always #5 clk = ~clk;

  bp_be_prefetch_scheduler dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .flush_i        (flush_i),
    .cand_v_i       (cand_v_i),
    .cand_confirm_i (cand_confirm_i),
    .cand_addr_i    (cand_addr_i),
    .cand_stride_i  (cand_stride_i),
    .cand_ready_o   (cand_ready_o),
    .pf_v_o         (pf_v_o),
    .pf_addr_o      (pf_addr_o),
    .pf_yumi_i      (pf_yumi_i),
    .idle_o         (idle_o)
  );

  // Every real consume must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset_i && !flush_i && pf_v_o && pf_yumi_i) begin
      n_chk++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL consume_unexpected: got %h, required none",
                 pf_addr_o);
      end else begin
        mon_exp = sb_q.pop_front();
        if (pf_addr_o !== mon_exp) begin
          n_fail++;
          $display("FAIL consume_addr: got %h, required %h",
                   pf_addr_o, mon_exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int j = 0; j < FE; j++) begin
      m_v[j] = 1'b0;
      m_tag[j] = '0;
    end
    m_rr = 0;
  endtask

  task automatic model_push(input logic [VA-1:0] a0,
                            input logic [7:0] s);
    logic [VA-1:0]        a;
    logic signed [VA-1:0] d;
    logic [VA-OFF-1:0]    t;
    bit                   hit;
    a = a0;
    d = VA'($signed(s));
    for (int k = 0; k < DEG; k++) begin
      a = a + d;
      t = a[VA-1:OFF];
      hit = 1'b0;
      for (int j = 0; j < FE; j++) begin
        if (m_v[j] && m_tag[j] == t) hit = 1'b1;
      end
      if (!hit) begin
        sb_q.push_back(a);
        m_v[m_rr] = 1'b1;
        m_tag[m_rr] = t;
        m_rr = (m_rr + 1) % FE;
      end
    end
  endtask

  task automatic drive_cand(input logic [VA-1:0] a,
                            input logic [7:0] s,
                            input logic conf,
                            input bit push);
    cand_v_i = 1'b1;
    cand_confirm_i = conf;
    cand_addr_i = a;
    cand_stride_i = s;
    if (push) model_push(a, s);
    cyc();
    cand_v_i = 1'b0;
    cand_confirm_i = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || idle_o !== 1'b1) && n < 400) begin
      cyc();
      n++;
    end
    n_chk++;
    if (sb_q.size() != 0 || idle_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_drain: left %0d idle %b, required 0 and 1",
               nm, sb_q.size(), idle_o);
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    pf_yumi_i = 1'b0;
    cyc();
    cyc();
    reset_i = 1'b0;
    model_clear();
    sb_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_chk += 4;
    if (pf_v_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pf_v: got %b, required 0", pf_v_o);
    end
    if (pf_addr_o !== '0) begin
      n_fail++;
      $display("FAIL reset_addr: got %h, required 0", pf_addr_o);
    end
    if (cand_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b, required 1", cand_ready_o);
    end
    if (idle_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_idle: got %b, required 1", idle_o);
    end
  endtask

  task automatic test_basic();
    pf_yumi_i = 1'b1;
    drive_cand(39'h1000, 8'h40, 1'b1, 1'b1);
    n_chk++;
    if (pf_v_o !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_n1_v: got %b, required 0", pf_v_o);
    end
    cyc();
    n_chk += 2;
    if (pf_v_o !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_n2_v: got %b, required 1", pf_v_o);
    end
    if (pf_addr_o !== 39'h1040) begin
      n_fail++;
      $display("FAIL basic_n2_addr: got %h, required 1040", pf_addr_o);
    end
    cyc();
    n_chk += 2;
    if (pf_v_o !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_n3_v: got %b, required 1", pf_v_o);
    end
    if (pf_addr_o !== 39'h1080) begin
      n_fail++;
      $display("FAIL basic_n3_addr: got %h, required 1080", pf_addr_o);
    end
    cyc();
    n_chk++;
    if (idle_o !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_idle: got %b, required 1", idle_o);
    end
    wait_drain("basic");
  endtask

  task automatic test_neg_stride();
    pf_yumi_i = 1'b1;
    drive_cand(39'h1000, 8'hC0, 1'b1, 1'b1);
    cyc();
    n_chk++;
    if (pf_addr_o !== 39'h0FC0) begin
      n_fail++;
      $display("FAIL neg_first: got %h, required 0fc0", pf_addr_o);
    end
    cyc();
    n_chk++;
    if (pf_addr_o !== 39'h0F80) begin
      n_fail++;
      $display("FAIL neg_second: got %h, required 0f80", pf_addr_o);
    end
    wait_drain("neg");
  endtask

  task automatic test_filter();
    do_reset();
    pf_yumi_i = 1'b1;
    drive_cand(39'h2000, 8'h40, 1'b1, 1'b1);
    wait_drain("filt_a");
    drive_cand(39'h2000, 8'h40, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (pf_v_o !== 1'b0) begin
        n_fail++;
        $display("FAIL filt_skip%0d: got %b, required 0", i, pf_v_o);
      end
      cyc();
    end
    n_chk++;
    if (idle_o !== 1'b1) begin
      n_fail++;
      $display("FAIL filt_skip_idle: got %b, required 1", idle_o);
    end
    drive_cand(39'h3000, 8'h40, 1'b1, 1'b1);
    wait_drain("filt_b");
    drive_cand(39'h4000, 8'h40, 1'b1, 1'b1);
    wait_drain("filt_c");
    drive_cand(39'h2000, 8'h40, 1'b1, 1'b1);
    cyc();
    n_chk++;
    if (pf_v_o !== 1'b1 || pf_addr_o !== 39'h2040) begin
      n_fail++;
      $display("FAIL filt_rotate: got v%b %h, required v1 2040",
               pf_v_o, pf_addr_o);
    end
    wait_drain("filt_d");
  endtask

  task automatic test_drop_events();
    pf_yumi_i = 1'b1;
    drive_cand(39'h5000, 8'h40, 1'b0, 1'b0);
    drive_cand(39'h6000, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (pf_v_o !== 1'b0 || idle_o !== 1'b1) begin
        n_fail++;
        $display("FAIL drop_%0d: got v%b idle%b, required v0 idle1",
                 i, pf_v_o, idle_o);
      end
      cyc();
    end
  endtask

  task automatic test_back_to_back();
    logic [VA-1:0] a;
    do_reset();
    pf_yumi_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a = VA'(32'h1000 * (i + 1));
      cand_v_i = 1'b1;
      cand_confirm_i = 1'b1;
      cand_addr_i = a;
      cand_stride_i = 8'h40;
      if (i == 4) begin
        n_chk++;
        if (cand_ready_o !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_ready4: got %b, required 1", cand_ready_o);
        end
      end
      if (i == 5) begin
        n_chk++;
        if (cand_ready_o !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_full: got %b, required 0", cand_ready_o);
        end
      end
      if (i < 5) model_push(a, 8'h40);
      cyc();
    end
    cand_v_i = 1'b0;
    cand_confirm_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (pf_v_o !== 1'b1 || pf_addr_o !== 39'h1040) begin
        n_fail++;
        $display("FAIL b2b_stall%0d: got v%b %h, required v1 1040",
                 i, pf_v_o, pf_addr_o);
      end
      cyc();
    end
    pf_yumi_i = 1'b1;
    wait_drain("b2b");
  endtask

  task automatic test_flush();
    pf_yumi_i = 1'b0;
    drive_cand(39'h8000, 8'h40, 1'b1, 1'b0);
    cyc();
    flush_i = 1'b1;
    pf_yumi_i = 1'b1;
    cand_v_i = 1'b1;
    cand_confirm_i = 1'b1;
    cand_addr_i = 39'h9000;
    cand_stride_i = 8'h40;
    n_chk++;
    if (pf_v_o !== 1'b1 || pf_addr_o !== 39'h8040) begin
      n_fail++;
      $display("FAIL flush_pre: got v%b %h, required v1 8040",
               pf_v_o, pf_addr_o);
    end
    cyc();
    flush_i = 1'b0;
    pf_yumi_i = 1'b0;
    cand_v_i = 1'b0;
    cand_confirm_i = 1'b0;
    model_clear();
    n_chk++;
    if (pf_v_o !== 1'b0 || idle_o !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_post: got v%b idle%b, required v0 idle1",
               pf_v_o, idle_o);
    end
    pf_yumi_i = 1'b1;
    drive_cand(39'h8000, 8'h40, 1'b1, 1'b1);
    cyc();
    n_chk++;
    if (pf_v_o !== 1'b1 || pf_addr_o !== 39'h8040) begin
      n_fail++;
      $display("FAIL flush_replay: got v%b %h, required v1 8040",
               pf_v_o, pf_addr_o);
    end
    wait_drain("flush_a");
    drive_cand(39'h5000, 8'h40, 1'b1, 1'b1);
    wait_drain("flush_b");
  endtask

  task automatic test_reset_mid();
    pf_yumi_i = 1'b0;
    drive_cand(39'hA000, 8'h40, 1'b1, 1'b0);
    cyc();
    reset_i = 1'b1;
    pf_yumi_i = 1'b1;
    cyc();
    reset_i = 1'b0;
    pf_yumi_i = 1'b0;
    model_clear();
    n_chk++;
    if (pf_v_o !== 1'b0 || idle_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_post: got v%b idle%b, required v0 idle1",
               pf_v_o, idle_o);
    end
    pf_yumi_i = 1'b1;
    drive_cand(39'hA000, 8'h40, 1'b1, 1'b1);
    wait_drain("rstmid");
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_neg_stride();
    test_filter();
    test_drop_events();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_sb: got %0d left, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
